// File: rtl/miner_pkg.sv
// miner_pkg: definitions shared by the hash target checker and its sub-block.
//   state_t      : scan FSM state encoding
//   HASH_WORDS   : 32-bit words per hash, word 0 most significant
//   FOUND_BIT /
//   NONCE_LSB    : field positions inside the one-word result record
//   make_record  : packs {found, 15'b0, nonce} into the result record
package miner_pkg;

  localparam int HASH_WORDS = 8;
  localparam int WORD_W     = 32;
  localparam int NONCE_W    = 16;
  localparam int FOUND_BIT  = 31;
  localparam int NONCE_LSB  = 0;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_REQ  = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_CMP     = 3'd3,
    ST_WRITE   = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  function automatic logic [WORD_W-1:0] make_record(input logic found,
                                                    input logic [NONCE_W-1:0] nonce);
    logic [WORD_W-1:0] rec;
    rec = 32'd0;
    rec[FOUND_BIT] = found;
    rec[NONCE_LSB +: NONCE_W] = nonce;
    return rec;
  endfunction

endpackage

// File: rtl/hash_word_cmp.sv
// hash_word_cmp: combinational unsigned compare of one 32-bit hash word
// against the matching 32-bit target word.
//   hash_word   in  32  word read back from memory
//   target_word in  32  target word at the same significance
//   cmp_res     out 3   {lt, eq, gt}, exactly one bit set
module hash_word_cmp
  import miner_pkg::*;
(
  input  logic [WORD_W-1:0] hash_word,
  input  logic [WORD_W-1:0] target_word,
  output logic [2:0]        cmp_res
);

  // one-hot relation of the hash word to the target word
  always_comb begin
    cmp_res = 3'b000;
    if (hash_word < target_word) begin
      cmp_res = 3'b100;
    end else if (hash_word == target_word) begin
      cmp_res = 3'b010;
    end else begin
      cmp_res = 3'b001;
    end
  end

endmodule

// File: rtl/hash_target_checker.sv
// hash_target_checker: scans NUM_NONCES 256-bit hashes held in memory, MSB
// word first, and reports the lowest nonce whose hash is strictly below the
// difficulty target. A one-word result record is written to result_addr.
//   clk, reset            clock and asynchronous active-high reset
//   start                 begin a scan (accepted only when idle)
//   hash_addr             base of hash block; word k of nonce n at base + k*NUM_NONCES + n
//   result_addr           address receiving {found, 15'b0, win_nonce}
//   target                difficulty target, [255:224] is word 0
//   done                  one-cycle pulse once the record is written
//   found, win_nonce      scan result, held until the next accepted start
//   mem_*                 single-port memory interface (mem_clk = clk)
module hash_target_checker
  import miner_pkg::*;
#(
  parameter int NUM_NONCES = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [15:0]  hash_addr,
  input  logic [15:0]  result_addr,
  input  logic [255:0] target,
  output logic         done,
  output logic         found,
  output logic [15:0]  win_nonce,
  output logic         mem_clk,
  output logic         mem_we,
  output logic [15:0]  mem_addr,
  output logic [31:0]  mem_write_data,
  input  logic [31:0]  mem_read_data
);

  localparam logic [15:0] STRIDE     = 16'(NUM_NONCES);
  localparam logic [15:0] LAST_NONCE = 16'(NUM_NONCES - 1);
  localparam logic [2:0]  LAST_WORD  = 3'(HASH_WORDS - 1);

  state_t        state_q, state_d;
  logic [255:0]  target_q, target_d;
  logic [15:0]   hash_addr_q, hash_addr_d;
  logic [15:0]   result_addr_q, result_addr_d;
  logic [15:0]   n_q, n_d;
  logic [2:0]    k_q, k_d;
  logic          found_q, found_d;
  logic [15:0]   win_nonce_q, win_nonce_d;
  logic          done_q, done_d;
  logic          mem_we_q, mem_we_d;
  logic [15:0]   mem_addr_q, mem_addr_d;
  logic [31:0]   mem_write_data_q, mem_write_data_d;

  logic [255:0]  tgt_shift_s;
  logic [31:0]   tgt_word_s;
  logic [2:0]    cmp_res_s;
  logic          cmp_lt_s;
  logic          cmp_eq_s;
  logic          cmp_gt_s;
  logic          nonce_fail_s;

  // Address arithmetic wraps at 16 bits, so a block may straddle 0xFFFF.
  function automatic logic [15:0] word_addr(input logic [15:0] base,
                                            input logic [2:0]  k,
                                            input logic [15:0] n);
    return base + (16'(k) * STRIDE) + n;
  endfunction

  // Shifting by k*32 brings target word k into the top 32 bits.
  assign tgt_shift_s = target_q << {k_q, 5'd0};
  assign tgt_word_s  = tgt_shift_s[255:224];

  hash_word_cmp u_cmp (
    .hash_word   (mem_read_data),
    .target_word (tgt_word_s),
    .cmp_res     (cmp_res_s)
  );

  assign cmp_lt_s = cmp_res_s[2];
  assign cmp_eq_s = cmp_res_s[1];
  assign cmp_gt_s = cmp_res_s[0];
  // A hash equal on every word is not strictly below the target.
  assign nonce_fail_s = cmp_gt_s | (cmp_eq_s & (k_q == LAST_WORD));

  assign mem_clk        = clk;
  assign done           = done_q;
  assign found          = found_q;
  assign win_nonce      = win_nonce_q;
  assign mem_we         = mem_we_q;
  assign mem_addr       = mem_addr_q;
  assign mem_write_data = mem_write_data_q;

  // state and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= ST_IDLE;
      target_q         <= 256'd0;
      hash_addr_q      <= 16'd0;
      result_addr_q    <= 16'd0;
      n_q              <= 16'd0;
      k_q              <= 3'd0;
      found_q          <= 1'b0;
      win_nonce_q      <= 16'd0;
      done_q           <= 1'b0;
      mem_we_q         <= 1'b0;
      mem_addr_q       <= 16'd0;
      mem_write_data_q <= 32'd0;
    end else begin
      state_q          <= state_d;
      target_q         <= target_d;
      hash_addr_q      <= hash_addr_d;
      result_addr_q    <= result_addr_d;
      n_q              <= n_d;
      k_q              <= k_d;
      found_q          <= found_d;
      win_nonce_q      <= win_nonce_d;
      done_q           <= done_d;
      mem_we_q         <= mem_we_d;
      mem_addr_q       <= mem_addr_d;
      mem_write_data_q <= mem_write_data_d;
    end
  end

  // next-state and next-output logic of the scan FSM
  always_comb begin
    state_d          = state_q;
    target_d         = target_q;
    hash_addr_d      = hash_addr_q;
    result_addr_d    = result_addr_q;
    n_d              = n_q;
    k_d              = k_q;
    found_d          = found_q;
    win_nonce_d      = win_nonce_q;
    done_d           = 1'b0;
    mem_we_d         = 1'b0;
    mem_addr_d       = mem_addr_q;
    mem_write_data_d = mem_write_data_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          target_d      = target;
          hash_addr_d   = hash_addr;
          result_addr_d = result_addr;
          n_d           = 16'd0;
          k_d           = 3'd0;
          found_d       = 1'b0;
          win_nonce_d   = 16'd0;
          mem_addr_d    = hash_addr;
          state_d       = ST_RD_REQ;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_RD_REQ: begin
        state_d = ST_RD_WAIT;
      end

      ST_RD_WAIT: begin
        state_d = ST_CMP;
      end

      ST_CMP: begin
        if (cmp_lt_s) begin
          // first winner ends the scan; lower nonces have already failed
          found_d          = 1'b1;
          win_nonce_d      = n_q;
          mem_we_d         = 1'b1;
          mem_addr_d       = result_addr_q;
          mem_write_data_d = make_record(1'b1, n_q);
          state_d          = ST_WRITE;
        end else if (nonce_fail_s) begin
          if (n_q != LAST_NONCE) begin
            n_d        = n_q + 16'd1;
            k_d        = 3'd0;
            mem_addr_d = word_addr(hash_addr_q, 3'd0, n_q + 16'd1);
            state_d    = ST_RD_REQ;
          end else begin
            found_d          = 1'b0;
            win_nonce_d      = 16'd0;
            mem_we_d         = 1'b1;
            mem_addr_d       = result_addr_q;
            mem_write_data_d = make_record(1'b0, 16'd0);
            state_d          = ST_WRITE;
          end
        end else begin
          // tie on this word: the next lower word decides
          k_d        = k_q + 3'd1;
          mem_addr_d = word_addr(hash_addr_q, k_q + 3'd1, n_q);
          state_d    = ST_RD_REQ;
        end
      end

      ST_WRITE: begin
        done_d  = 1'b1;
        state_d = ST_DONE;
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule
